// File: rtl/denormalize_if.sv
// Handshake bundle for the denormalizer: operand in, aligned mantissa plus rounding bits out.
interface denormalize_if #(
    parameter int WIDTH = 48
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in;
    logic [7:0]       shift_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             guard;
    logic             round;
    logic             sticky;
    logic             zero;

    modport master (
        output in_valid, in, shift_amt, out_ready,
        input  in_ready, out_valid, out, guard, round, sticky, zero
    );

    modport slave (
        input  in_valid, in, shift_amt, out_ready,
        output in_ready, out_valid, out, guard, round, sticky, zero
    );
endinterface

// File: rtl/denormalize.sv
// Multi-cycle mantissa right-shifter: aligns a mantissa by up to STEP bits per cycle,
// keeping guard/round bits below the LSB and a sticky OR of everything shifted past them.
module denormalize #(
    parameter int WIDTH = 48,
    parameter int STEP  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    denormalize_if.slave  bus
);
    localparam int         DW     = WIDTH + 2;
    localparam logic [7:0] LIMIT  = 8'(DW);
    localparam logic [7:0] STEP_C = 8'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [DW-1:0] data_r;
    logic [DW-1:0] data_s;
    logic [DW-1:0] lost_mask_s;
    logic          sticky_r;
    logic          sticky_s;
    logic [7:0]    rem_r;
    logic [7:0]    rem_s;
    logic [7:0]    step_s;

    // Per-cycle shift distance and the mask of bits that fall off the bottom this cycle.
    always_comb begin
        step_s      = STEP_C;
        lost_mask_s = {DW{1'b0}};
        if (rem_r < STEP_C) begin
            step_s = rem_r;
        end else begin
            step_s = STEP_C;
        end
        lost_mask_s = ~({DW{1'b1}} << step_s);
    end

    // Next-state and datapath update for the accept / shift / present sequence.
    always_comb begin
        state_s  = state_r;
        data_s   = data_r;
        sticky_s = sticky_r;
        rem_s    = rem_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    data_s   = {bus.in, 2'b00};
                    sticky_s = 1'b0;
                    // Anything at or beyond the full register width clears it entirely.
                    if (bus.shift_amt >= LIMIT) begin
                        rem_s = LIMIT;
                    end else begin
                        rem_s = bus.shift_amt;
                    end
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                data_s   = data_r >> step_s;
                sticky_s = sticky_r | (|(data_r & lost_mask_s));
                rem_s    = rem_r - step_s;
                if (rem_r == step_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            data_r   <= {DW{1'b0}};
            sticky_r <= 1'b0;
            rem_r    <= 8'd0;
        end else begin
            state_r  <= state_s;
            data_r   <= data_s;
            sticky_r <= sticky_s;
            rem_r    <= rem_s;
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.out       = data_r[DW-1:2];
    assign bus.guard     = data_r[1];
    assign bus.round     = data_r[0];
    assign bus.sticky    = sticky_r;
    assign bus.zero      = ~((|data_r) | sticky_r);
endmodule

// File: tb/tb_denormalize.sv
// Directed bench for denormalize: arithmetic reference model checked every cycle,
// plus literal expectations for the reference operations.
module tb_denormalize;
    localparam int W  = 48;
    localparam int ST = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    denormalize_if #(.WIDTH(W)) ifc ();

    denormalize #(.WIDTH(W), .STEP(ST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    bit checking = 1'b0;

    // Model state: idle/busy/presenting, cycles left, and the result it will present.
    bit         m_idle  = 1'b1;
    bit         m_valid = 1'b0;
    bit         m_clean = 1'b1;
    int         m_left  = 0;
    logic [W-1:0] m_out, p_out;
    logic m_g, m_r, m_s, p_g, p_r, p_s;
    int p_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: shift the full-width value at once and OR together what falls below round.
    task automatic model_calc(input logic [W-1:0] v, input logic [7:0] amt,
                              output logic [W-1:0] o, output logic g, output logic r,
                              output logic s, output int n);
        int sh;
        logic [63:0] ext, res, mask;
        sh   = (int'(amt) > W + 2) ? W + 2 : int'(amt);
        ext  = {14'd0, v, 2'b00};
        res  = ext >> sh;
        mask = (64'd1 << sh) - 64'd1;
        o = res[W+1:2];
        g = res[1];
        r = res[0];
        s = |(ext & mask);
        n = (sh == 0) ? 1 : (sh + ST - 1) / ST;
    endtask

    // Cycle-level model driven by the handshake inputs and the latency rule.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_idle = 1'b1; m_valid = 1'b0; m_clean = 1'b1; m_left = 0;
        end else if (m_idle) begin
            if (ifc.in_valid) begin
                model_calc(ifc.in, ifc.shift_amt, p_out, p_g, p_r, p_s, p_n);
                m_left  = p_n;
                m_idle  = 1'b0;
                m_clean = 1'b0;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1'b1;
                m_out = p_out; m_g = p_g; m_r = p_r; m_s = p_s;
            end
        end else if (m_valid && ifc.out_ready) begin
            m_valid = 1'b0;
            m_idle  = 1'b1;
        end
    end

    // Compare DUT against the model on the falling edge.
    always @(negedge clk) begin
        if (checking) begin
            chk("in_ready", ifc.in_ready, m_idle);
            chk("out_valid", ifc.out_valid, m_valid);
            if (m_valid) begin
                chk("out", ifc.out, m_out);
                chk("guard", ifc.guard, m_g);
                chk("round", ifc.round, m_r);
                chk("sticky", ifc.sticky, m_s);
                chk("zero", ifc.zero, (m_out == '0) && !m_g && !m_r && !m_s);
            end else if (m_clean) begin
                chk("clean_out", ifc.out, 64'd0);
                chk("clean_grs", {ifc.guard, ifc.round, ifc.sticky}, 64'd0);
                chk("clean_zero", ifc.zero, 64'd1);
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (!ifc.in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("wait_idle", ifc.in_ready, 64'd1);
    endtask

    task automatic wait_valid(input int elat, input string tag);
        int lat = 1;
        while (!ifc.out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, "_latency"}, lat, elat);
    endtask

    task automatic run_op(input logic [W-1:0] v, input logic [7:0] amt,
                          input logic [W-1:0] eo, input logic eg, input logic er,
                          input logic es, input int elat, input string tag);
        wait_idle();
        ifc.in_valid = 1'b1; ifc.in = v; ifc.shift_amt = amt;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        wait_valid(elat, tag);
        chk({tag, "_out"}, ifc.out, eo);
        chk({tag, "_grs"}, {ifc.guard, ifc.round, ifc.sticky}, {eg, er, es});
        chk({tag, "_zero"}, ifc.zero, (eo == '0) && !eg && !er && !es);
        if (ifc.out_ready) begin
            @(posedge clk); #1;
            chk({tag, "_back_idle"}, {ifc.in_ready, ifc.out_valid}, 64'b10);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ifc.in_valid = 1'b0; ifc.in = '0; ifc.shift_amt = 8'd0; ifc.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checking = 1'b1;
        chk("rst_ready_valid", {ifc.in_ready, ifc.out_valid}, 64'b10);
        chk("rst_out", ifc.out, 64'd0);
        chk("rst_zero", ifc.zero, 64'd1);
        rst_n = 1'b1;

        run_op(48'h800000000000, 8'd0,  48'h800000000000, 1'b0, 1'b0, 1'b0, 2, "shift0");
        run_op(48'h00000000000F, 8'd3,  48'h000000000001, 1'b1, 1'b1, 1'b1, 2, "shift3");
        run_op(48'hFFFFFFFFFFFF, 8'd20, 48'h00000FFFFFFF, 1'b1, 1'b1, 1'b1, 4, "shift20");
        run_op(48'h000000000001, 8'd60, 48'h000000000000, 1'b0, 1'b0, 1'b1, 8, "sat60");
        run_op(48'h123456789ABC, 8'd8,  48'h00123456789A, 1'b1, 1'b0, 1'b1, 2, "shift8");
        run_op(48'h800000000000, 8'd49, 48'h000000000000, 1'b0, 1'b1, 1'b0, 8, "shift49");
        run_op(48'h800000000000, 8'd50, 48'h000000000000, 1'b0, 1'b0, 1'b1, 8, "shift50");
        run_op(48'h000000000001, 8'd1,  48'h000000000000, 1'b1, 1'b0, 1'b0, 2, "shift1");
        run_op(48'h000000000000, 8'd5,  48'h000000000000, 1'b0, 1'b0, 1'b0, 2, "zero_in");
        run_op(48'hABCDEF123456, 8'd255, 48'h000000000000, 1'b0, 1'b0, 1'b1, 8, "sat255");

        // Backpressure: result held while in_valid keeps offering new operands.
        ifc.out_ready = 1'b0;
        run_op(48'h0000FFFF0000, 8'd16, 48'h00000000FFFF, 1'b0, 1'b0, 1'b0, 3, "bp");
        for (int i = 0; i < 5; i++) begin
            ifc.in_valid  = 1'b1;
            ifc.in        = W'({$urandom(), $urandom()});
            ifc.shift_amt = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            chk("bp_hold_out", ifc.out, 48'h00000000FFFF);
            chk("bp_in_ready", {ifc.in_ready, ifc.out_valid}, 64'b01);
        end
        ifc.in = 48'h00000000000F; ifc.shift_amt = 8'd3;
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", {ifc.in_ready, ifc.out_valid}, 64'b10);
        @(posedge clk); #1;
        chk("bp_reaccept", ifc.in_ready, 64'd0);
        ifc.in_valid = 1'b0;
        wait_valid(2, "bp_next");
        chk("bp_next_out", ifc.out, 48'h000000000001);
        chk("bp_next_grs", {ifc.guard, ifc.round, ifc.sticky}, 64'b111);
        @(posedge clk); #1;

        // Reset during the second shift cycle, with in_valid high at the reset edge.
        wait_idle();
        ifc.in_valid = 1'b1; ifc.in = 48'hFFFFFFFFFFFF; ifc.shift_amt = 8'd20;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        ifc.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("midrst_state", {ifc.in_ready, ifc.out_valid}, 64'b10);
        chk("midrst_zero", ifc.zero, 64'd1);
        chk("midrst_out", ifc.out, 64'd0);
        rst_n = 1'b1;
        ifc.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_result", ifc.out_valid, 64'd0);
        end

        run_op(48'hFFFFFFFFFFFF, 8'd20, 48'h00000FFFFFFF, 1'b1, 1'b1, 1'b1, 4, "post_rst");

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/denormalize.md
DENORMALIZE -- requirements
Module: denormalize

Interface
REQ-001 SHALL have parameter WIDTH, default 48, the mantissa field width.
REQ-002 SHALL have parameter STEP, default 8, the maximum right-shift bit positions per cycle.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, high when input operand is offered.
REQ-006 SHALL have port in_ready, output, 1, high when the block can accept an operand.
REQ-007 SHALL have port in, input, WIDTH, the unshifted mantissa.
REQ-008 SHALL have port shift_amt, input, 8, the right-shift distance, i.e. the exponent difference.
REQ-009 SHALL have port out_valid, output, 1, high when the result is available.
REQ-010 SHALL have port out_ready, input, 1, high when the consumer takes the result.
REQ-011 SHALL have port out, output, WIDTH, the aligned mantissa.
REQ-012 SHALL have ports guard, round and sticky, output, 1 each, the rounding bits below out[0].
REQ-013 SHALL have port zero, output, 1, high when out, guard, round and sticky are all 0.

Function
REQ-014 SHALL hold an internal data register of WIDTH+2 bits, {mantissa, guard, round}, a sticky register, a remaining-shift counter and a 2-bit state register.
REQ-015 SHALL implement states IDLE, SHIFT and DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-017 SHALL, in IDLE on in_valid&&in_ready, load data={in,2'b00}, clear sticky, set remaining=min(shift_amt, WIDTH+2), and go to SHIFT.
REQ-018 SHALL, on each SHIFT cycle, apply step=min(remaining, STEP) as follows:
- data becomes data>>step;
- sticky becomes sticky OR (OR of the step bits shifted out);
- remaining becomes remaining-step.
REQ-019 SHALL move from SHIFT to DONE on the cycle where remaining-step==0; with shift_amt=0, exactly one SHIFT cycle with step 0 occurs.
REQ-020 SHALL give a latency of n=max(1, ceil(min(shift_amt,WIDTH+2)/STEP)) SHIFT cycles; out_valid rises n+1 edges after the accepting edge.
REQ-021 SHALL present out=data[WIDTH+1:2], guard=data[1] and round=data[0] directly from registers.
REQ-022 SHALL hold out, guard, round, sticky and zero stable while out_valid=1 and out_ready=0.
REQ-023 SHALL return to IDLE on out_valid&&out_ready; results are not buffered, so no new accept occurs in that same cycle.
REQ-024 SHALL ignore in_valid, in and shift_amt outside IDLE.
REQ-025 SHALL saturate shift_amt values of WIDTH+2 or more; the result is then out=0, guard=0, round=0 and sticky=|in.
REQ-026 SHALL compute zero combinationally from the registered outputs.

Reset
REQ-027 SHALL, on rising edge with rst_n=0, set state=IDLE, data=0, sticky=0 and remaining=0.
REQ-028 SHALL give the following output values after reset:
- in_ready=1, out_valid=0;
- out=0, guard=0, round=0, sticky=0;
- zero=1.
REQ-029 SHALL abandon any in-progress shift or pending result on reset, in any state, with no output.
REQ-030 SHALL give reset priority over all handshakes in the same cycle.

Verification
REQ-031 SHALL cover shift by zero: in=48'h800000000000, shift_amt=0, out_ready=1 -> out=48'h800000000000, guard=0, round=0, sticky=0; out_valid 2 edges after accept.
REQ-032 SHALL cover a small shift: in=48'h00000000000F, shift_amt=3 -> out=48'h000000000001, guard=1, round=1, sticky=1; one SHIFT cycle.
REQ-033 SHALL cover a multi-cycle shift: in=48'hFFFFFFFFFFFF, shift_amt=20 -> out=48'h00000FFFFFFF, guard=1, round=1, sticky=1; three SHIFT cycles (8,8,4); out_valid 4 edges after accept.
REQ-034 SHALL cover saturation: in=48'h000000000001, shift_amt=60 -> out=0, guard=0, round=0, sticky=1, zero=0; seven SHIFT cycles.
REQ-035 SHALL cover backpressure: out_ready=0 for 5 cycles in DONE, with in_valid held high and changing in -> out stable, in_ready=0; then out_ready=1 -> IDLE next edge, and a new accept on the following edge.
REQ-036 SHALL cover reset mid-operation: rst_n=0 during the second SHIFT cycle of the REQ-033 operation -> next edge gives IDLE, in_ready=1, out_valid=0, zero=1; no result ever produced.
